// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port among NUM_PORTS requesters with fixed-priority or
// round-robin arbitration, and steers each read response back to its requester.
module sram_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int RD_LAT    = 1,
  parameter int ARB_MODE  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_en,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_stall,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        mem_en,
  output logic [DATA_W/8-1:0]         mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Handshake: a request is accepted in the cycle req_en[i]=1 and req_stall[i]=0.
  // While stalled the requester holds every request field stable; nothing is buffered here.

  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_any;
  logic [IDX_W-1:0]     grant_idx;

  logic                 trk_vld [RD_LAT];
  logic [IDX_W-1:0]     trk_idx [RD_LAT];

  // Candidate port k steps after the last winner, wrapping at NUM_PORTS.
  function automatic logic [IDX_W-1:0] rr_cand(input logic [IDX_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return IDX_W'(s);
  endfunction

  always_comb begin : arbitrate
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (rst_n) begin
      if (ARB_MODE == 0) begin
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
          if (req_en[i]) begin
            grant_any = 1'b1;
            grant_idx = IDX_W'(i);
          end
        end
      end else begin
        // Walk from farthest to nearest so the nearest requester overwrites.
        for (int k = NUM_PORTS; k >= 1; k--) begin
          if (req_en[rr_cand(rr_ptr, k)]) begin
            grant_any = 1'b1;
            grant_idx = rr_cand(rr_ptr, k);
          end
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  assign req_stall = req_en & ~grant;

  always_comb begin : mem_mux
    mem_en    = grant_any;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        mem_we    = mem_we    | req_we[i*BE_W +: BE_W];
        mem_addr  = mem_addr  | req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = mem_wdata | req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= IDX_W'(NUM_PORTS - 1);
    end else if (grant_any) begin
      rr_ptr <= grant_idx;
    end
  end

  // Tracker stage 0 captures the grant cycle; stage RD_LAT-1 lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        trk_vld[i] <= 1'b0;
        trk_idx[i] <= '0;
      end
    end else begin
      trk_vld[0] <= grant_any && (mem_we == '0);
      trk_idx[0] <= grant_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        trk_vld[i] <= trk_vld[i-1];
        trk_idx[i] <= trk_idx[i-1];
      end
    end
  end

  always_comb begin : rsp_route
    rsp_valid = '0;
    rsp_rdata = '0;
    if (rst_n && trk_vld[RD_LAT-1]) begin
      rsp_valid[trk_idx[RD_LAT-1]] = 1'b1;
      rsp_rdata                    = mem_rdata;
    end
  end

  a_grant_onehot : assert property (@(posedge clk) $onehot0(grant));
  a_rsp_onehot   : assert property (@(posedge clk) $onehot0(rsp_valid));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: four configurations share one clock; a monitor
// checks every read response against an expected queue filled at issue time.
module tb_sram_port_arbiter;

  typedef struct packed {
    logic [1:0]  dut;
    logic [15:0] cyc;
    logic [3:0]  vld;
    logic [63:0] data;
  } exp_t;

  localparam int EW = $bits(exp_t);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cyc = '0;
  logic        expect_rsp;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  logic [3:0]   en    [4];
  logic [31:0]  we    [4];
  logic [127:0] addr  [4];
  logic [255:0] wdata [4];

  wire  [3:0]  stall  [4];
  wire  [3:0]  rv     [4];
  wire  [63:0] rdata  [4];
  wire         men    [4];
  wire  [7:0]  mwe    [4];
  wire  [31:0] maddr  [4];
  wire  [63:0] mwdata [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  function automatic logic [63:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 64'hDEAD : {~a, a ^ 32'h5A5A_0000};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 2) ? 3 : ((d == 3) ? 2 : 1);
  endfunction

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    localparam int NP   = (g == 3) ? 4 : 2;
    localparam int LAT  = (g == 2) ? 3 : ((g == 3) ? 2 : 1);
    localparam int MODE = (g == 1) ? 0 : 1;

    logic [NP-1:0] s_stall;
    logic [NP-1:0] s_rv;
    logic [63:0]   s_mrdata;
    logic [63:0]   pipe [LAT];

    sram_port_arbiter #(
      .NUM_PORTS(NP), .ADDR_W(32), .DATA_W(64), .RD_LAT(LAT), .ARB_MODE(MODE)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_en    (en[g][NP-1:0]),
      .req_we    (we[g][NP*8-1:0]),
      .req_addr  (addr[g][NP*32-1:0]),
      .req_wdata (wdata[g][NP*64-1:0]),
      .req_stall (s_stall),
      .rsp_valid (s_rv),
      .rsp_rdata (rdata[g]),
      .mem_en    (men[g]),
      .mem_we    (mwe[g]),
      .mem_addr  (maddr[g]),
      .mem_wdata (mwdata[g]),
      .mem_rdata (s_mrdata)
    );

    assign stall[g] = 4'(s_stall);
    assign rv[g]    = 4'(s_rv);

    // Memory model: read data appears LAT cycles after an enabled read.
    always @(posedge clk) begin
      pipe[0] <= (men[g] && mwe[g] == 8'h0) ? mem_fn(maddr[g]) : 64'h0;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign s_mrdata = pipe[LAT-1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear(input int d);
    en[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
  endtask

  task automatic set_port(input int d, input int p, input logic [7:0] w, input logic [31:0] a);
    en[d][p]          = 1'b1;
    we[d][p*8 +: 8]   = w;
    addr[d][p*32 +: 32] = a;
  endtask

  // One cycle: inputs are already applied; win is the expected winner or -1.
  task automatic step(input int d, input int win);
    logic [3:0] oh;
    logic [7:0] w;
    exp_t       e;
    oh = (win >= 0) ? (4'b1 << win) : 4'b0;
    @(negedge clk);
    chk("req_stall", 64'(stall[d]), 64'(en[d] & ~oh));
    chk("mem_en", 64'(men[d]), 64'(win >= 0));
    if (win >= 0) begin
      w = we[d][win*8 +: 8];
      chk("mem_addr", 64'(maddr[d]), 64'(addr[d][win*32 +: 32]));
      chk("mem_we", 64'(mwe[d]), 64'(w));
      if (w != 8'h0) begin
        chk("mem_wdata", mwdata[d], wdata[d][win*64 +: 64]);
      end else if (expect_rsp) begin
        e.dut  = 2'(d);
        e.cyc  = cyc + 16'(lat_of(d));
        e.vld  = oh;
        e.data = mem_fn(addr[d][win*32 +: 32]);
        exp_q.push_back(e);
      end
    end else begin
      chk("mem_addr_idle", 64'(maddr[d]), 64'h0);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response pulse pops and checks the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (rv[d] != 4'h0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rv[d]), 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_dut", 64'(d), 64'(e.dut));
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
          chk("rsp_valid", 64'(rv[d]), 64'(e.vld));
          chk("rsp_rdata", rdata[d], e.data);
        end
      end else begin
        chk("rsp_rdata_idle", rdata[d], 64'h0);
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      if (e.cyc < cyc) begin
        chk("rsp_missing", 64'(cyc), 64'(e.cyc));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    expect_rsp = 1'b1;
    for (int d = 0; d < 4; d++) clear(d);
    repeat (2) @(posedge clk);
    #1;

    // Reset: stall mirrors req_en, no memory access, no responses.
    set_port(0, 0, 8'h00, 32'h10);
    set_port(0, 1, 8'h00, 32'h20);
    step(0, -1);
    clear(0);
    rst_n = 1'b1;

    // Round-robin, both ports continuously: 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++) begin
      set_port(0, 0, 8'h00, 32'h200 + 32'(i / 2) * 8);
      set_port(0, 1, 8'h00, 32'h300 + 32'(i / 2) * 8);
      step(0, i % 2);
    end
    clear(0);
    step(0, -1);

    // Single read of 0x100 returns 0xDEAD one cycle later.
    set_port(0, 0, 8'h00, 32'h100);
    step(0, 0);
    clear(0);
    step(0, -1);
    step(0, -1);

    // Fixed priority: port 0 wins all four cycles.
    for (int i = 0; i < 4; i++) begin
      set_port(1, 0, 8'h00, 32'h400 + 32'(i) * 8);
      set_port(1, 1, 8'h00, 32'h500);
      step(1, 0);
    end
    clear(1);
    step(1, -1);
    step(1, -1);

    // RD_LAT=3: write from port 1 then read from port 0.
    set_port(2, 1, 8'hFF, 32'h800);
    wdata[2][64 +: 64] = 64'h1122_3344_5566_7788;
    step(2, 1);
    clear(2);
    set_port(2, 0, 8'h00, 32'h900);
    step(2, 0);
    clear(2);
    repeat (4) step(2, -1);

    // Two reads in flight, then one reset cycle drops both.
    expect_rsp = 1'b0;
    set_port(2, 0, 8'h00, 32'hA00);
    step(2, 0);
    clear(2);
    set_port(2, 1, 8'h00, 32'hB00);
    step(2, 1);
    clear(2);
    rst_n = 1'b0;
    set_port(2, 0, 8'h00, 32'hC00);
    set_port(2, 1, 8'h00, 32'hD00);
    step(2, -1);
    rst_n      = 1'b1;
    expect_rsp = 1'b1;
    step(2, 0);
    en[2][0] = 1'b0;
    step(2, 1);
    clear(2);
    repeat (5) step(2, -1);

    // Four ports, only 1 and 3 requesting: 1,3,1,3,1,3 with no idle cycle.
    for (int i = 0; i < 6; i++) begin
      set_port(3, 1, 8'h00, 32'h600 + 32'(i / 2) * 8);
      set_port(3, 3, 8'h00, 32'h700 + 32'(i / 2) * 8);
      step(3, (i % 2 == 0) ? 1 : 3);
    end
    clear(3);
    repeat (3) step(3, -1);

    chk("exp_q_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
